adder_sequencer: RTL and testbench
==================================

ADDER_SEQUENCER -- requirements
Module: adder_sequencer

Interface
REQ-001 Parameter: NBYTES, default 2, number of 8-bit adder passes per operation (operand width W = 8*NBYTES, NBYTES >= 1).
REQ-002 Port: CLK  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: RST  input  1  synchronous, active-high reset.
REQ-004 Port: REQ0, REQ1  input  1 each  operation request from requester 0 / 1.
REQ-005 Port: OPA0, OPB0, OPA1, OPB1  input  W each  operands of requester 0 / 1.
REQ-006 Port: SUB0, SUB1  input  1 each  1 = A-B, 0 = A+B, per requester.
REQ-007 Port: ACK0, ACK1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-008 Port: BUSY  output  1  high in RUN and DONE states.
REQ-009 Port: RES  output  W  result of the last completed operation.
REQ-010 Port: RES_C, RES_V, RES_Z  output  1 each  final carry, signed overflow, result-equals-zero.
REQ-011 Port: ADD_A, ADD_B  output  8 each  operand byte driven to the external 8-bit adder.
REQ-012 Port: ADD_CI  output  1  carry-in to the external adder.
REQ-013 Port: ADD_Y  input  8; ADD_C  input  1; ADD_V  input  1  combinational sum, carry-out, overflow returned by the adder in the same cycle.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE; reset state IDLE.
REQ-015 IDLE: if neither REQ high, stay IDLE; if exactly one high, grant it; if both high, grant the requester named by the round-robin pointer PTR.
REQ-016 On grant: latch OPA, OPB, SUB of granted requester, record grant ID, byte index IDX <= 0, go RUN.
REQ-017 RUN, byte IDX: ADD_A = latched A[8*IDX+7:8*IDX]; ADD_B = latched B byte, bitwise inverted when SUB=1.
REQ-018 ADD_CI for IDX=0 SHALL equal SUB; for IDX>0 SHALL equal the ADD_C registered at the previous pass.
REQ-019 Each RUN cycle SHALL write ADD_Y into internal result byte IDX and register ADD_C; IDX increments.
REQ-020 At IDX = NBYTES-1 the block SHALL also capture ADD_C as final carry and ADD_V as overflow, then go DONE.
REQ-021 DONE (one cycle): RES, RES_C, RES_V, RES_Z update from the internal result; ACK of granted ID pulses high; PTR <= other ID; go IDLE.
REQ-022 Latency: request sampled in IDLE at edge t -> ACK high during cycle t+NBYTES+1; RES valid from that cycle until the next DONE.
REQ-023 Subtraction carry convention: RES_C = 1 means no borrow (A >= B unsigned).
REQ-024 RES_Z SHALL be 1 iff all W result bits are 0.
REQ-025 Requester SHALL hold REQ and operands until its ACK and deassert REQ at the edge ending the ACK cycle; a REQ high in IDLE is always a new request.
REQ-026 REQ changes while RUN/DONE SHALL be ignored; operand changes after grant SHALL not affect the result.
REQ-027 In IDLE and DONE, ADD_A, ADD_B, ADD_CI SHALL be 0.
REQ-028 ACK0 and ACK1 SHALL never be high in the same cycle; at most one ACK per grant.
REQ-029 Only one requester served per operation; a losing requester is served by the next IDLE grant (no starvation).

Reset
REQ-030 RST high at an edge SHALL force IDLE, PTR=0, IDX=0, RES=0, RES_C=RES_V=RES_Z=0, ACK0=ACK1=0, BUSY=0, adder drive 0.
REQ-031 RST during RUN or DONE SHALL abort: no ACK issued, RES not updated, aborted requester must re-request.
REQ-032 RST has priority over all other events in the same cycle.

Verification (NBYTES=2)
REQ-033 REQ0, add 0x00FF+0x0001 -> ACK0 3 cycles after grant edge, RES=0x0100, C=0, V=0, Z=0.
REQ-034 REQ1, sub 0x0005-0x0007 -> ACK1, RES=0xFFFE, C=0 (borrow), V=0; ADD_CI=1 on first pass.
REQ-035 REQ0, add 0x7FFF+0x0001 -> RES=0x8000, V=1, C=0; add 0xFFFF+0x0001 -> RES=0x0000, C=1, Z=1.
REQ-036 REQ0 and REQ1 both high from reset -> requester 0 served first, then requester 1; second simultaneous pair served 0 then 1 again only per PTR (alternation checked).
REQ-037 RST asserted in cycle 2 of RUN -> no ACK, all outputs 0 next cycle; subsequent REQ1 add 0x1234+0x1111 -> RES=0x2345 normally.
REQ-038 Operands changed on the cycle after grant -> RES reflects grant-time operands.

Source files
------------

// File: rtl/adder_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : adder_sequencer
//  Purpose  : Two-requester front end for an external 8-bit adder. The
//             granted W-bit add or subtract is executed one byte per cycle,
//             least significant byte first, and the carry is rippled
//             between passes through a register.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NBYTES            number of 8-bit passes per operation (W = 8*NBYTES)
//  Ports
//    CLK, RST          clock, synchronous active-high reset
//    REQ0/1            operation request from requester 0 / 1
//    OPA0/1, OPB0/1    W-bit operands of requester 0 / 1
//    SUB0/1            1 = A-B, 0 = A+B
//    ACK0/1            one-cycle completion pulse
//    BUSY              operation in progress (RUN or DONE)
//    RES, RES_C/V/Z    result, final carry, signed overflow, zero flag
//    ADD_A/B/CI        byte operands and carry-in to the external adder
//    ADD_Y/C/V         combinational sum, carry-out, overflow from the adder
// ============================================================================
module adder_sequencer #(
    parameter int NBYTES = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                REQ0,
    input  logic                REQ1,
    input  logic [8*NBYTES-1:0] OPA0,
    input  logic [8*NBYTES-1:0] OPB0,
    input  logic [8*NBYTES-1:0] OPA1,
    input  logic [8*NBYTES-1:0] OPB1,
    input  logic                SUB0,
    input  logic                SUB1,
    output logic                ACK0,
    output logic                ACK1,
    output logic                BUSY,
    output logic [8*NBYTES-1:0] RES,
    output logic                RES_C,
    output logic                RES_V,
    output logic                RES_Z,
    output logic [7:0]          ADD_A,
    output logic [7:0]          ADD_B,
    output logic                ADD_CI,
    input  logic [7:0]          ADD_Y,
    input  logic                ADD_C,
    input  logic                ADD_V
);

    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_next;

    logic            ptr;        // round-robin winner when both request
    logic            gnt;        // ID of the requester being served
    logic [IDXW-1:0] idx;        // byte currently on the adder
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic            sub_l;
    logic            carry;      // carry-out of the previous pass
    logic [W-1:0]    res_int;    // bytes completed so far

    logic            any_req;
    logic            grant_sel;
    logic            last_pass;
    logic [7:0]      a_byte;
    logic [7:0]      b_byte;
    logic [W-1:0]    res_merged; // res_int with the current pass's sum inserted

    assign any_req   = REQ0 | REQ1;
    // A lone request wins outright; a tie goes to the pointer.
    assign grant_sel = (REQ0 & REQ1) ? ptr : REQ1;
    assign last_pass = (idx == LAST_IDX);

    always_comb begin
        a_byte     = '0;
        b_byte     = '0;
        res_merged = res_int;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx == IDXW'(i)) begin
                a_byte               = op_a[8*i +: 8];
                b_byte               = op_b[8*i +: 8];
                res_merged[8*i +: 8] = ADD_Y;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (any_req)   state_next = S_RUN;
            S_RUN:   if (last_pass) state_next = S_DONE;
            S_DONE:                 state_next = S_IDLE;
            default:                state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        ADD_A  = '0;
        ADD_B  = '0;
        ADD_CI = 1'b0;
        BUSY   = 1'b0;
        ACK0   = 1'b0;
        ACK1   = 1'b0;
        case (state)
            S_RUN: begin
                BUSY   = 1'b1;
                ADD_A  = a_byte;
                // Subtraction is A + ~B + 1, the +1 entering as the first carry-in.
                ADD_B  = sub_l ? ~b_byte : b_byte;
                ADD_CI = (idx == '0) ? sub_l : carry;
            end
            S_DONE: begin
                BUSY = 1'b1;
                // A reset arriving in DONE aborts, so the pulse is withheld.
                ACK0 = ~gnt & ~RST;
                ACK1 =  gnt & ~RST;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr     <= 1'b0;
            gnt     <= 1'b0;
            idx     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            sub_l   <= 1'b0;
            carry   <= 1'b0;
            res_int <= '0;
            RES     <= '0;
            RES_C   <= 1'b0;
            RES_V   <= 1'b0;
            RES_Z   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        gnt   <= grant_sel;
                        op_a  <= grant_sel ? OPA1 : OPA0;
                        op_b  <= grant_sel ? OPB1 : OPB0;
                        sub_l <= grant_sel ? SUB1 : SUB0;
                        idx   <= '0;
                    end
                end
                S_RUN: begin
                    res_int <= res_merged;
                    carry   <= ADD_C;
                    idx     <= idx + 1'b1;
                    // Publish on the final pass so RES is already valid
                    // while ACK is high in DONE.
                    if (last_pass) begin
                        RES   <= res_merged;
                        RES_C <= ADD_C;
                        RES_V <= ADD_V;
                        RES_Z <= (res_merged == '0);
                    end
                end
                S_DONE: begin
                    ptr <= ~gnt;
                    idx <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_sequencer
//  Purpose  : Self-checking bench for adder_sequencer (NBYTES=2) with an
//             external 8-bit adder model and an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adder_sequencer;

    localparam int NB = 2;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [W-1:0] opa0, opb0, opa1, opb1;
    logic         sub0, sub1;
    logic         ack0, ack1, busy;
    logic [W-1:0] res;
    logic         res_c, res_v, res_z;
    logic [7:0]   add_a, add_b, add_y;
    logic         add_ci, add_c, add_v;

    int n_chk = 0;
    int n_err = 0;
    bit tb_ptr = 1'b0;

    always #5 clk = ~clk;

    adder_sequencer #(.NBYTES(NB)) dut (
        .CLK(clk), .RST(rst),
        .REQ0(req0), .REQ1(req1),
        .OPA0(opa0), .OPB0(opb0), .OPA1(opa1), .OPB1(opb1),
        .SUB0(sub0), .SUB1(sub1),
        .ACK0(ack0), .ACK1(ack1), .BUSY(busy),
        .RES(res), .RES_C(res_c), .RES_V(res_v), .RES_Z(res_z),
        .ADD_A(add_a), .ADD_B(add_b), .ADD_CI(add_ci),
        .ADD_Y(add_y), .ADD_C(add_c), .ADD_V(add_v)
    );

    // External 8-bit adder
    always_comb begin
        {add_c, add_y} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_ci};
        add_v = (add_a[7] == add_b[7]) && (add_y[7] != add_a[7]);
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {Z, V, C, result} from whole-word arithmetic
    function automatic logic [W+2:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        longint ua, ub, sa, sb, r, sr, smax, smin;
        logic [W-1:0] y;
        logic c, v;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        r    = s ? (ua - ub) : (ua + ub);
        y    = r[W-1:0];
        c    = s ? (ua >= ub) : (r >= (longint'(1) << W));
        sr   = s ? (sa - sb) : (sa + sb);
        v    = (sr > smax) || (sr < smin);
        return {(y == '0), v, c, y};
    endfunction

    // Serve every currently raised request, checking arbitration order,
    // latency, first-pass adder drive and the published result.
    task automatic serve(input bit scramble);
        bit           pend0, pend1, g, first;
        int           lat, k;
        logic [W-1:0] ga, gb;
        logic         gs;
        logic [W+2:0] e;
        pend0 = req0;
        pend1 = req1;
        first = 1'b1;
        while (pend0 || pend1) begin
            g   = (pend0 && pend1) ? tb_ptr : pend1;
            ga  = g ? opa1 : opa0;
            gb  = g ? opb1 : opb0;
            gs  = g ? sub1 : sub0;
            e   = ref_op(ga, gb, gs);
            lat = first ? NB + 1 : NB + 2;
            k   = 0;
            do begin
                @(negedge clk);
                k++;
                if (k == lat - NB) begin
                    check_value("first_ci", add_ci, gs);
                    check_value("first_a", add_a, ga[7:0]);
                    if (scramble) begin
                        if (g) begin opa1 = W'($urandom); opb1 = W'($urandom); sub1 = ~sub1; end
                        else   begin opa0 = W'($urandom); opb0 = W'($urandom); sub0 = ~sub0; end
                    end
                end
            end while (!(ack0 || ack1) && k < 3 * NB + 8);
            check_value("ack_latency", k, lat);
            check_value("ack_id", {ack1, ack0}, g ? 2'b10 : 2'b01);
            check_value("busy_done", busy, 1'b1);
            check_value("res", res, e[W-1:0]);
            check_value("res_c", res_c, e[W]);
            check_value("res_v", res_v, e[W+1]);
            check_value("res_z", res_z, e[W+2]);
            if (g) begin req1 = 1'b0; pend1 = 1'b0; end
            else   begin req0 = 1'b0; pend0 = 1'b0; end
            tb_ptr = ~g;
            first  = 1'b0;
        end
        @(negedge clk);
        check_value("idle_busy", busy, 1'b0);
    endtask

    task automatic set_op(input bit who, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        if (who) begin req1 = 1'b1; opa1 = a; opb1 = b; sub1 = s; end
        else     begin req0 = 1'b1; opa0 = a; opb0 = b; sub0 = s; end
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, "_acks"}, {ack1, ack0}, 2'b00);
        check_value({tag, "_busy"}, busy, 1'b0);
        check_value({tag, "_res"}, res, '0);
        check_value({tag, "_flags"}, {res_c, res_v, res_z}, 3'b000);
        check_value({tag, "_adder"}, {add_a, add_b, add_ci}, 17'd0);
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        opa0 = '0; opb0 = '0; opa1 = '0; opb1 = '0;
        sub0 = 1'b0; sub1 = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        tb_ptr = 1'b0;

        // Simultaneous requests from reset, twice: expect 0,1 then 0,1
        set_op(1'b0, 16'h1111, 16'h2222, 1'b0);
        set_op(1'b1, 16'h8000, 16'h0001, 1'b1);
        serve(1'b0);
        set_op(1'b0, 16'hA5A5, 16'h5A5A, 1'b0);
        set_op(1'b1, 16'h0003, 16'h0003, 1'b1);
        serve(1'b0);

        // Directed arithmetic corners
        set_op(1'b0, 16'h00FF, 16'h0001, 1'b0); serve(1'b0);
        set_op(1'b1, 16'h0005, 16'h0007, 1'b1); serve(1'b0);
        set_op(1'b0, 16'h7FFF, 16'h0001, 1'b0); serve(1'b0);
        set_op(1'b0, 16'hFFFF, 16'h0001, 1'b0); serve(1'b0);

        // Operands changed right after grant
        set_op(1'b1, 16'h4321, 16'h1234, 1'b1); serve(1'b1);

        // Reset in the second RUN cycle aborts the operation
        set_op(1'b0, 16'h0F0F, 16'h0101, 1'b0);
        @(negedge clk);
        check_value("abort_ack1", {ack1, ack0}, 2'b00);
        @(negedge clk);
        check_value("abort_ack2", {ack1, ack0}, 2'b00);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("abort");
        rst = 1'b0;
        req0 = 1'b0;
        tb_ptr = 1'b0;
        set_op(1'b1, 16'h1234, 16'h1111, 1'b0); serve(1'b0);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            bit r0, r1;
            r0 = 1'($urandom);
            r1 = 1'($urandom);
            if (!r0 && !r1) r0 = 1'b1;
            if (r0) set_op(1'b0, W'($urandom), W'($urandom), 1'($urandom));
            if (r1) set_op(1'b1, W'($urandom), W'($urandom), 1'($urandom));
            if (($urandom % 5) == 0) begin
                opb0 = opa0;
                sub0 = 1'b1;
            end
            serve(1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
